// File: rtl/game_round_engine.sv
// Round engine downstream of the game controller: lights targets, scores hits/misses, runs the game timer.
// Optional build macro MISS_PENALTY_EN: each miss also decrements score (floored at 0).
module game_round_engine #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter logic [7:0]  GAME_TICKS   = 8'd200,
  parameter logic [7:0]  TARGET_TICKS = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  output logic [2:0] lamp,
  output logic [7:0] score,
  output logic [7:0] time_left,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       stop_out
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef MISS_PENALTY_EN
  localparam bit MISS_PENALTY = 1'b1;
`else
  localparam bit MISS_PENALTY = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    SHOW = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [2:0]       btn_q;
  logic             start_q;
  logic [2:0]       target;
  logic [7:0]       tgt_cnt;
  logic [DIV_W-1:0] div;

  logic [2:0] btn_c;
  logic [2:0] rise_c;
  logic       start_rise_c;
  logic       tick_c;
  logic       hit_c;
  logic       miss_press_c;
  logic       timeout_c;
  logic       lfsr_fb_c;
  logic [2:0] next_target_c;
  logic [7:0] score_inc_c;
  logic [7:0] score_dec_c;

  assign btn_c        = {btn3, btn2, btn1};
  assign rise_c       = btn_c & ~btn_q;
  assign start_rise_c = start_game & ~start_q;
  assign tick_c       = (div == DIV_W'(TICK_DIV - 1));
  assign hit_c        = (rise_c == target);
  assign miss_press_c = (rise_c != 3'b000) && !hit_c;
  assign timeout_c    = tick_c && (tgt_cnt == (TARGET_TICKS - 8'd1));
  assign lfsr_fb_c    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign score_inc_c  = (score == 8'hFF) ? score : score + 8'd1;
  assign score_dec_c  = (score == 8'h00) ? score : score - 8'd1;

  // Code 3 avoids a bias toward any lamp by stepping from the previous target
  always_comb begin
    next_target_c = 3'b001;
    case (lfsr[1:0])
      2'd0:    next_target_c = 3'b001;
      2'd1:    next_target_c = 3'b010;
      2'd2:    next_target_c = 3'b100;
      default: next_target_c = {target[1:0], target[2]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= 8'hA5;
      btn_q      <= 3'b000;
      start_q    <= 1'b0;
      target     <= 3'b001;
      tgt_cnt    <= 8'd0;
      div        <= '0;
      lamp       <= 3'b000;
      score      <= 8'd0;
      time_left  <= 8'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      stop_out   <= 1'b0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr_fb_c};
      btn_q      <= btn_c;
      start_q    <= start_game;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (start_rise_c) begin
            state     <= ARM;
            score     <= 8'd0;
            time_left <= GAME_TICKS;
            div       <= '0;
          end
        end

        ARM, SHOW, GAP: begin
          if (!start_game) begin
            // Abort: score and time_left are left as they were
            state <= IDLE;
            lamp  <= 3'b000;
          end else begin
            div <= tick_c ? '0 : div + DIV_W'(1);
            if (tick_c && (time_left != 8'd0)) begin
              time_left <= time_left - 8'd1;
            end

            case (state)
              ARM: begin
                target  <= next_target_c;
                lamp    <= next_target_c;
                tgt_cnt <= 8'd0;
                state   <= SHOW;
              end
              SHOW: begin
                if (tick_c) begin
                  tgt_cnt <= tgt_cnt + 8'd1;
                end
                if (hit_c) begin
                  score     <= score_inc_c;
                  hit_pulse <= 1'b1;
                  lamp      <= 3'b000;
                  state     <= GAP;
                end else if (miss_press_c || timeout_c) begin
                  miss_pulse <= 1'b1;
                  if (MISS_PENALTY) begin
                    score <= score_dec_c;
                  end
                  if (timeout_c) begin
                    lamp  <= 3'b000;
                    state <= GAP;
                  end
                end
              end
              GAP: begin
                if (tick_c) begin
                  state <= ARM;
                end
              end
              default: ;
            endcase

            // Expiry overrides the round outcome, but a same-cycle hit is still scored above
            if (time_left == 8'd0) begin
              state    <= DONE;
              lamp     <= 3'b000;
              stop_out <= 1'b1;
            end
          end
        end

        DONE: begin
          if (!start_game) begin
            state    <= IDLE;
            stop_out <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          lamp  <= 3'b000;
        end
      endcase
    end
  end

endmodule
